// File: rtl/puf_mem_arbiter_if.sv
// Requester-side bus for puf_mem_arbiter: two request/grant ports and the shared read-data return.
interface puf_mem_arbiter_if #(
    parameter int unsigned ADDR_SZ = 8,
    parameter int unsigned DATA_SZ = 264
);
    logic               r0_req;
    logic               r0_we;
    logic [ADDR_SZ-1:0] r0_addr;
    logic [DATA_SZ-1:0] r0_wdata;
    logic               r0_gnt;
    logic               r0_rvalid;

    logic               r1_req;
    logic               r1_we;
    logic [ADDR_SZ-1:0] r1_addr;
    logic [DATA_SZ-1:0] r1_wdata;
    logic               r1_gnt;
    logic               r1_rvalid;

    logic [DATA_SZ-1:0] rd_data;

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rd_data
    );

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rd_data
    );
endinterface

// File: rtl/puf_mem_arbiter.sv
// Shares one single-port mem between PUF capture (r0) and host readout (r1); zero-fills mem after reset.
// Define PUF_MEM_ARB_FIXED_PRIO_EN for strict r0 priority instead of round-robin.
module puf_mem_arbiter #(
    parameter int unsigned ADDR_SZ = 8,
    parameter int unsigned DATA_SZ = 264,
    parameter int unsigned DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    puf_mem_arbiter_if.slave   bus,
    output logic               init_done,
    output logic               mem_we,
    output logic [ADDR_SZ-1:0] mem_addr,
    output logic [DATA_SZ-1:0] mem_wdata,
    input  logic [DATA_SZ-1:0] mem_rdata
);
    typedef enum logic {INIT_CLR, ARB} state_t;

    state_t             state;
    logic [ADDR_SZ-1:0] clr_addr;
    logic [ADDR_SZ-1:0] addr_q;
    logic               r0_rvalid_q;
    logic               r1_rvalid_q;
    logic               gnt0;
    logic               gnt1;
`ifndef PUF_MEM_ARB_FIXED_PRIO_EN
    logic               last_gnt;   // 1 = r1 won last, so r0 wins the next tie
`endif

    // Same-cycle grant decision
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == ARB) begin
`ifdef PUF_MEM_ARB_FIXED_PRIO_EN
            gnt0 = bus.r0_req;
            gnt1 = bus.r1_req & ~bus.r0_req;
`else
            if (bus.r0_req && bus.r1_req) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = bus.r0_req;
                gnt1 = bus.r1_req;
            end
`endif
        end
    end

    // Memory port mux; address holds its last value when idle
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        if (!rst_n) begin
            mem_addr = '0;
        end else if (state == INIT_CLR) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr;
        end else if (gnt0) begin
            mem_we    = bus.r0_we;
            mem_addr  = bus.r0_addr;
            mem_wdata = bus.r0_wdata;
        end else if (gnt1) begin
            mem_we    = bus.r1_we;
            mem_addr  = bus.r1_addr;
            mem_wdata = bus.r1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT_CLR;
            clr_addr    <= '0;
            addr_q      <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            init_done   <= 1'b0;
`ifndef PUF_MEM_ARB_FIXED_PRIO_EN
            last_gnt    <= 1'b1;
`endif
        end else begin
            addr_q      <= mem_addr;
            r0_rvalid_q <= gnt0 & ~bus.r0_we;
            r1_rvalid_q <= gnt1 & ~bus.r1_we;
            case (state)
                INIT_CLR: begin
                    clr_addr <= clr_addr + ADDR_SZ'(1);
                    if (clr_addr == ADDR_SZ'(DEPTH - 1)) begin
                        state     <= ARB;
                        init_done <= 1'b1;
                    end
                end
                ARB: begin
`ifndef PUF_MEM_ARB_FIXED_PRIO_EN
                    if (gnt0) begin
                        last_gnt <= 1'b0;
                    end else if (gnt1) begin
                        last_gnt <= 1'b1;
                    end
`endif
                end
                default: state <= INIT_CLR;
            endcase
        end
    end

    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.r0_rvalid = r0_rvalid_q;
    assign bus.r1_rvalid = r1_rvalid_q;
    // Read data comes straight from the mem output register
    assign bus.rd_data   = mem_rdata;
endmodule

// File: tb/tb_puf_mem_arbiter.sv
// Self-checking bench for puf_mem_arbiter with a behavioural read-first mem and a transaction-level model.
module tb_puf_mem_arbiter;
    localparam int unsigned ADDR_SZ = 8;
    localparam int unsigned DATA_SZ = 264;
    localparam int unsigned DEPTH   = 8;
`ifdef PUF_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               init_done;
    logic               mem_we;
    logic [ADDR_SZ-1:0] mem_addr;
    logic [DATA_SZ-1:0] mem_wdata;
    logic [DATA_SZ-1:0] mem_rdata;

    always #5 clk = ~clk;

    puf_mem_arbiter_if #(.ADDR_SZ(ADDR_SZ), .DATA_SZ(DATA_SZ)) bus ();

    puf_mem_arbiter #(.ADDR_SZ(ADDR_SZ), .DATA_SZ(DATA_SZ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port mem: registered read, read-first on write
    logic [DATA_SZ-1:0] mem_arr [DEPTH];
    always @(posedge clk) begin
        if (int'(mem_addr) < int'(DEPTH)) begin
            mem_rdata <= mem_arr[mem_addr[2:0]];
            if (mem_we) mem_arr[mem_addr[2:0]] <= mem_wdata;
        end else begin
            mem_rdata <= '0;
        end
    end

    int checks = 0;
    int errors = 0;

    // Transaction-level reference model
    logic [DATA_SZ-1:0] ref_mem [DEPTH];
    int                 last_w;      // requester granted most recently
    int                 pend;        // 0 none, 1 r0 read due, 2 r1 read due
    logic [DATA_SZ-1:0] pend_data;
    logic               exp_g0, exp_g1, exp_rv0, exp_rv1, exp_we;
    logic [DATA_SZ-1:0] exp_rd, exp_wdata;
    logic [ADDR_SZ-1:0] exp_addr;

    function automatic logic [DATA_SZ-1:0] rand_word();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        return t[DATA_SZ-1:0];
    endfunction

    task automatic model_init();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        last_w    = 1;
        pend      = 0;
        pend_data = '0;
        exp_addr  = ADDR_SZ'(DEPTH - 1);
    endtask

    // Evaluate one ARB cycle from the currently driven requests
    task automatic model_step();
        int                 w;
        logic               we;
        logic [ADDR_SZ-1:0] a;
        logic [DATA_SZ-1:0] d;
        exp_rv0 = (pend == 1);
        exp_rv1 = (pend == 2);
        exp_rd  = pend_data;
        w = -1;
        if (bus.r0_req && bus.r1_req) w = FIXED ? 0 : ((last_w == 0) ? 1 : 0);
        else if (bus.r0_req) w = 0;
        else if (bus.r1_req) w = 1;
        exp_g0    = (w == 0);
        exp_g1    = (w == 1);
        exp_we    = 1'b0;
        exp_wdata = '0;
        pend      = 0;
        if (w >= 0) begin
            we = (w == 0) ? bus.r0_we    : bus.r1_we;
            a  = (w == 0) ? bus.r0_addr  : bus.r1_addr;
            d  = (w == 0) ? bus.r0_wdata : bus.r1_wdata;
            exp_addr = a;
            exp_we   = we;
            if (we) begin
                exp_wdata = d;
                ref_mem[a[2:0]] = d;
            end else begin
                pend      = w + 1;
                pend_data = ref_mem[a[2:0]];
            end
            last_w = w;
        end
    endtask

    task automatic set_r0(input logic req, input logic we, input int addr, input logic [DATA_SZ-1:0] d);
        bus.r0_req = req; bus.r0_we = we; bus.r0_addr = ADDR_SZ'(addr); bus.r0_wdata = d;
    endtask

    task automatic set_r1(input logic req, input logic we, input int addr, input logic [DATA_SZ-1:0] d);
        bus.r1_req = req; bus.r1_we = we; bus.r1_addr = ADDR_SZ'(addr); bus.r1_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_r0(1'b1, 1'b1, 0, '0);
        set_r1(1'b0, 1'b0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.r0_gnt !== 1'b0 || bus.r1_gnt !== 1'b0 || mem_we !== 1'b0 ||
                mem_addr !== '0 || mem_wdata !== '0 || init_done !== 1'b0 ||
                bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc%0d got gnt=%b%b we=%b addr=%0h init=%b rv=%b%b exp all 0",
                         i, bus.r0_gnt, bus.r1_gnt, mem_we, mem_addr, init_done, bus.r0_rvalid, bus.r1_rvalid);
            end
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ADDR_SZ'(i) || mem_wdata !== '0 ||
                bus.r0_gnt !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL init_clear cyc%0d got we=%b addr=%0h wd0=%b gnt0=%b init=%b exp we=1 addr=%0h wd0=1 gnt0=0 init=0",
                         i, mem_we, mem_addr, (mem_wdata == '0), bus.r0_gnt, init_done, i);
            end
            tick();
        end
        @(negedge clk);
        model_init();
        model_step();
        checks++;
        if (init_done !== 1'b1 || bus.r0_gnt !== exp_g0 || mem_we !== exp_we) begin
            errors++;
            $display("FAIL init_done_first_grant got init=%b gnt0=%b we=%b exp init=1 gnt0=%b we=%b",
                     init_done, bus.r0_gnt, mem_we, exp_g0, exp_we);
        end
        tick();
        set_r0(1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_write_read();
        set_r0(1'b1, 1'b1, 3, DATA_SZ'(264'hA5));
        @(negedge clk);
        model_step();
        checks++;
        if (bus.r0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_SZ'(3) || mem_wdata !== DATA_SZ'(264'hA5)) begin
            errors++;
            $display("FAIL wr_grant got gnt0=%b we=%b addr=%0h wd=%0h exp 1 1 3 a5", bus.r0_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        set_r0(1'b0, 1'b0, 0, '0);
        set_r1(1'b1, 1'b0, 3, '0);
        @(negedge clk);
        model_step();
        checks++;
        if (bus.r1_gnt !== 1'b1 || bus.r0_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== ADDR_SZ'(3)) begin
            errors++;
            $display("FAIL rd_grant got gnt1=%b gnt0=%b we=%b addr=%0h exp 1 0 0 3", bus.r1_gnt, bus.r0_gnt, mem_we, mem_addr);
        end
        tick();
        set_r1(1'b0, 1'b0, 0, '0);
        @(negedge clk);
        model_step();
        checks++;
        if (bus.r1_rvalid !== 1'b1 || bus.r0_rvalid !== 1'b0 || bus.rd_data !== DATA_SZ'(264'hA5) || exp_rd !== DATA_SZ'(264'hA5)) begin
            errors++;
            $display("FAIL rd_return got rv1=%b rv0=%b data=%0h exp rv1=1 rv0=0 data=a5", bus.r1_rvalid, bus.r0_rvalid, bus.rd_data);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [DATA_SZ-1:0] d;
        d = rand_word();
        set_r0(1'b1, 1'b1, 4, d);
        set_r1(1'b1, 1'b0, 3, '0);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                set_r0(1'b0, 1'b0, 0, '0);
                set_r1(1'b0, 1'b0, 0, '0);
            end
            @(negedge clk);
            model_step();
            checks++;
            if (bus.r0_gnt !== exp_g0 || bus.r1_gnt !== exp_g1 || bus.r0_rvalid !== exp_rv0 ||
                bus.r1_rvalid !== exp_rv1 || ((exp_rv0 || exp_rv1) && bus.rd_data !== exp_rd)) begin
                errors++;
                $display("FAIL contention cyc%0d got gnt=%b%b rv=%b%b exp gnt=%b%b rv=%b%b",
                         i, bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, exp_g0, exp_g1, exp_rv0, exp_rv1);
            end
            checks++;
            if (i < 6 && bus.r0_gnt !== ((FIXED || (i % 2 == 0)) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL contention_order cyc%0d got gnt0=%b", i, bus.r0_gnt);
            end
            tick();
            if (exp_g0) bus.r0_wdata = rand_word();
        end
    endtask

    task automatic test_back_to_back();
        set_r0(1'b1, 1'b1, 5, DATA_SZ'(1));
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_r0(1'b1, 1'b0, 5, '0);
            if (i == 2) set_r0(1'b0, 1'b0, 0, '0);
            @(negedge clk);
            model_step();
            checks++;
            if (bus.r0_gnt !== exp_g0 || bus.r0_rvalid !== exp_rv0 || bus.r1_rvalid !== 1'b0 ||
                mem_we !== exp_we || (exp_rv0 && bus.rd_data !== DATA_SZ'(1))) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got gnt0=%b rv0=%b rv1=%b we=%b data=%0h exp gnt0=%b rv0=%b we=%b data=1",
                         i, bus.r0_gnt, bus.r0_rvalid, bus.r1_rvalid, mem_we, bus.rd_data, exp_g0, exp_rv0, exp_we);
            end
            tick();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            model_step();
            checks++;
            if (mem_we !== 1'b0 || bus.r0_gnt !== 1'b0 || bus.r1_gnt !== 1'b0 ||
                bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0 || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL idle cyc%0d got we=%b gnt=%b%b rv=%b%b addr=%0h exp all 0 addr=%0h",
                         i, mem_we, bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, mem_addr, exp_addr);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic has0, has1;
        has0 = 1'b0;
        has1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!has0 && $urandom_range(9, 0) < 6) begin
                set_r0(1'b1, 1'($urandom_range(1, 0)), $urandom_range(DEPTH - 1, 0), rand_word());
                has0 = 1'b1;
            end
            if (!has1 && $urandom_range(9, 0) < 6) begin
                set_r1(1'b1, 1'($urandom_range(1, 0)), $urandom_range(DEPTH - 1, 0), rand_word());
                has1 = 1'b1;
            end
            bus.r0_req = has0;
            bus.r1_req = has1;
            @(negedge clk);
            model_step();
            checks++;
            if (bus.r0_gnt !== exp_g0 || bus.r1_gnt !== exp_g1 || bus.r0_rvalid !== exp_rv0 ||
                bus.r1_rvalid !== exp_rv1 || mem_we !== exp_we || mem_addr !== exp_addr ||
                (exp_we && mem_wdata !== exp_wdata) || ((exp_rv0 || exp_rv1) && bus.rd_data !== exp_rd)) begin
                errors++;
                $display("FAIL random cyc%0d got gnt=%b%b rv=%b%b we=%b addr=%0h data=%0h exp gnt=%b%b rv=%b%b we=%b addr=%0h data=%0h",
                         i, bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, mem_we, mem_addr, bus.rd_data,
                         exp_g0, exp_g1, exp_rv0, exp_rv1, exp_we, exp_addr, exp_rd);
            end
            tick();
            if (exp_g0) has0 = 1'b0;
            if (exp_g1) has1 = 1'b0;
        end
        set_r0(1'b0, 1'b0, 0, '0);
        set_r1(1'b0, 1'b0, 0, '0);
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        set_r0(1'b1, 1'b1, 2, DATA_SZ'(264'hFF));
        @(negedge clk);
        model_step();
        checks++;
        if (bus.r0_gnt !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_write got gnt0=%b we=%b exp 1 1", bus.r0_gnt, mem_we);
        end
        tick();
        set_r0(1'b0, 1'b0, 0, '0);
        set_r1(1'b1, 1'b0, 2, '0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.r1_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset_cycle got gnt1=%b we=%b addr=%0h exp 0 0 0", bus.r1_gnt, mem_we, mem_addr);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ADDR_SZ'(i) || bus.r1_rvalid !== 1'b0 ||
                bus.r1_gnt !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL reclear cyc%0d got we=%b addr=%0h rv1=%b gnt1=%b init=%b exp 1 %0h 0 0 0",
                         i, mem_we, mem_addr, bus.r1_rvalid, bus.r1_gnt, init_done, i);
            end
            tick();
        end
        model_init();
        @(negedge clk);
        model_step();
        checks++;
        if (init_done !== 1'b1 || bus.r1_gnt !== exp_g1) begin
            errors++;
            $display("FAIL reinit_grant got init=%b gnt1=%b exp 1 %b", init_done, bus.r1_gnt, exp_g1);
        end
        tick();
        set_r1(1'b0, 1'b0, 0, '0);
        @(negedge clk);
        model_step();
        checks++;
        if (bus.r1_rvalid !== 1'b1 || bus.rd_data !== '0 || exp_rd !== '0) begin
            errors++;
            $display("FAIL reinit_read got rv1=%b data=%0h exp rv1=1 data=0", bus.r1_rvalid, bus.rd_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_idle();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
